// File: rtl/ctrl_rw_cas_scheduler.sv
// ctrl_rw_cas_scheduler: read/write column-command scheduler.
// Separate RD/WR FIFOs feed one CAS offer per slot. Same-direction CAS are batched.
// Spacing enforces tCCD and read->write / write->read turnaround.
// Write-queue watermarks decide when to change direction.
// Optional macro STARVE_GUARD_EN limits a same-direction run to MAX_RUN grants.
module ctrl_rw_cas_scheduler #(
    parameter int DEPTH   = 8,
    parameter int AW      = 16,
    parameter int WR_HI   = 6,
    parameter int WR_LO   = 2,
    parameter int MAX_RUN = 8
) (
    input  logic                       CK_t_i,
    input  logic                       reset_i,
    input  logic                       rd_valid_i,
    output logic                       rd_ready_o,
    input  logic                       rd_ap_i,
    input  logic [AW-1:0]              rd_addr_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       wr_ap_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [4:0]                 tccd_i,
    input  logic [5:0]                 trtw_i,
    input  logic [5:0]                 twtr_i,
    output logic                       cas_valid_o,
    input  logic                       cas_ready_i,
    output logic [2:0]                 cas_req_o,
    output logic [AW-1:0]              cas_addr_o,
    output logic [$clog2(DEPTH):0]     rd_count_o,
    output logic [$clog2(DEPTH):0]     wr_count_o,
    output logic                       sched_idle_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(MAX_RUN + 1) + 1;
    localparam logic [2:0] RD_R = 3'd1, RDA_R = 3'd2, WR_R = 3'd3, WRA_R = 3'd4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;          // 0 = RD, 1 = WR (target of TURN)
    logic [RW-1:0]   run_q, run_d;
    logic [5:0]      elapsed_q, same_gap_q, opp_gap_q;
    logic            last_wr_q;             // direction of the most recent issue

    logic [AW:0]     rd_mem [DEPTH];
    logic [AW:0]     wr_mem [DEPTH];
    logic [PW-1:0]   rd_wp_q, rd_rp_q, wr_wp_q, wr_rp_q;
    logic [CW-1:0]   rd_cnt_q, wr_cnt_q, rd_left, wr_left;
    logic            rd_push, wr_push, rd_pop, wr_pop, issue, can_move, run_hit;
    logic [AW:0]     rd_head, wr_head;
    logic [5:0]      tccd_eff, opp_t, gap_rd, gap_wr, gap_dir;
    logic            met_rd, met_wr, turn_ok;

    // A full queue refuses pushes even when it pops in the same cycle.
    assign rd_ready_o = (rd_cnt_q != CW'(DEPTH));
    assign wr_ready_o = (wr_cnt_q != CW'(DEPTH));
    assign rd_push    = rd_valid_i & rd_ready_o;
    assign wr_push    = wr_valid_i & wr_ready_o;
    assign rd_head    = rd_mem[rd_rp_q];
    assign wr_head    = wr_mem[wr_rp_q];
    assign issue      = cas_valid_o & cas_ready_i;
    assign rd_pop     = issue & (state_q == S_RD);
    assign wr_pop     = issue & (state_q == S_WR);
    assign rd_left    = rd_cnt_q - CW'(rd_pop);
    assign wr_left    = wr_cnt_q - CW'(wr_pop);
    assign can_move   = ~(cas_valid_o & ~cas_ready_i);
    assign run_hit    = GUARD_EN & issue & ((run_q + RW'(1)) >= RW'(MAX_RUN));
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
    assign sched_idle_o = (state_q == S_IDLE) && (rd_cnt_q == '0) && (wr_cnt_q == '0);

    // Queue storage; entries are {ap, addr}
    always_ff @(posedge CK_t_i) begin
        if (rd_push) rd_mem[rd_wp_q] <= {rd_ap_i, rd_addr_i};
        if (wr_push) wr_mem[wr_wp_q] <= {wr_ap_i, wr_addr_i};
    end

    // Queue pointers and occupancy
    always_ff @(posedge CK_t_i) begin
        if (reset_i) begin
            rd_wp_q <= '0; rd_rp_q <= '0; rd_cnt_q <= '0;
            wr_wp_q <= '0; wr_rp_q <= '0; wr_cnt_q <= '0;
        end else begin
            if (rd_push) rd_wp_q <= rd_wp_q + 1'b1;
            if (rd_pop)  rd_rp_q <= rd_rp_q + 1'b1;
            if (wr_push) wr_wp_q <= wr_wp_q + 1'b1;
            if (wr_pop)  wr_rp_q <= wr_rp_q + 1'b1;
            rd_cnt_q <= rd_cnt_q + CW'(rd_push) - CW'(rd_pop);
            wr_cnt_q <= wr_cnt_q + CW'(wr_push) - CW'(wr_pop);
        end
    end

    // Spacing: gaps are captured at each issue; elapsed counts cycles since it
    always_comb begin
        tccd_eff = (tccd_i == 5'd0) ? 6'd1 : {1'b0, tccd_i};
        opp_t    = (state_q == S_WR) ? twtr_i : trtw_i;
        gap_rd   = last_wr_q ? opp_gap_q : same_gap_q;
        gap_wr   = last_wr_q ? same_gap_q : opp_gap_q;
        gap_dir  = dir_q ? gap_wr : gap_rd;
        met_rd   = (elapsed_q >= gap_rd);
        met_wr   = (elapsed_q >= gap_wr);
        // TURN releases one cycle early so the new state offers on the first legal cycle
        turn_ok  = (({1'b0, elapsed_q} + 7'd1) >= {1'b0, gap_dir});
    end

    // Offer: head of the active direction once spacing is met; stable until issue
    always_comb begin
        cas_valid_o = 1'b0;
        cas_req_o   = 3'd0;
        cas_addr_o  = '0;
        if (state_q == S_RD && rd_cnt_q != '0 && met_rd) begin
            cas_valid_o = 1'b1;
            cas_req_o   = rd_head[AW] ? RDA_R : RD_R;
            cas_addr_o  = rd_head[AW-1:0];
        end else if (state_q == S_WR && wr_cnt_q != '0 && met_wr) begin
            cas_valid_o = 1'b1;
            cas_req_o   = wr_head[AW] ? WRA_R : WR_R;
            cas_addr_o  = wr_head[AW-1:0];
        end
    end

    // Direction FSM: no state change while an offer waits for cas_ready
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        run_d   = run_q;
        if (issue && run_q != RW'(MAX_RUN)) run_d = run_q + RW'(1);
        case (state_q)
            S_IDLE: begin
                run_d = '0;
                if (rd_cnt_q != '0 && wr_cnt_q < CW'(WR_HI)) begin
                    state_d = S_RD; dir_d = 1'b0;
                end else if (wr_cnt_q != '0) begin
                    state_d = S_WR; dir_d = 1'b1;
                end
            end
            S_RD: if (can_move) begin
                if (rd_left == '0 && wr_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_left == '0 || wr_cnt_q >= CW'(WR_HI) ||
                             (run_hit && wr_cnt_q != '0)) begin
                    state_d = S_TURN; dir_d = 1'b1; run_d = '0;
                end
            end
            S_WR: if (can_move) begin
                if (wr_left == '0 && rd_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_cnt_q != '0 && (wr_left == '0 || run_hit ||
                             (issue && wr_left <= CW'(WR_LO)))) begin
                    state_d = S_TURN; dir_d = 1'b0; run_d = '0;
                end
            end
            default: begin
                if (rd_cnt_q == '0 && wr_cnt_q == '0) state_d = S_IDLE;
                else if (turn_ok) state_d = dir_q ? S_WR : S_RD;
            end
        endcase
    end

    // State, run counter and spacing registers
    always_ff @(posedge CK_t_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            run_q      <= '0;
            elapsed_q  <= '0;
            same_gap_q <= '0;
            opp_gap_q  <= '0;
            last_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            run_q   <= run_d;
            if (issue) begin
                elapsed_q  <= 6'd1;
                same_gap_q <= tccd_eff;
                opp_gap_q  <= (opp_t > tccd_eff) ? opp_t : tccd_eff;
                last_wr_q  <= (state_q == S_WR);
            end else if (elapsed_q != 6'h3f) begin
                elapsed_q <= elapsed_q + 6'd1;
            end
        end
    end
endmodule
